// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per clock, shift-add multiply and restoring divide.
// Optional macro MULDIV_FASTPATH_EN: zero operands and div special cases bypass the iteration.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [2:0]       MulDivOp,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Negative,
   output logic             Busy
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, srca_q, srca_d, quo_q, quo_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [2:0]         op_q, op_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_q, neg_d, neg_rem_q, neg_rem_d, bzero_q, bzero_d;
   logic               zero_q, zero_d, negf_q, negf_d, out_valid_q, out_valid_d;
`ifdef MULDIV_FASTPATH_EN
   logic               fast_q, fast_d;
   logic [WIDTH-1:0]   fast_res_q, fast_res_d;
   logic               fast_hit, in_ovf;
   logic [WIDTH-1:0]   fast_val;
`endif

   // Operand decode at the accept edge
   logic             in_is_div, a_sgn, b_sgn, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   assign in_is_div = MulDivOp[2];
   assign a_sgn     = in_is_div ? ~MulDivOp[0] : (MulDivOp == 3'b001 || MulDivOp == 3'b010);
   assign b_sgn     = in_is_div ? ~MulDivOp[0] : (MulDivOp == 3'b001);
   assign a_neg     = a_sgn & SrcA[WIDTH-1];
   assign b_neg     = b_sgn & SrcB[WIDTH-1];
   assign a_mag     = a_neg ? -SrcA : SrcA;
   assign b_mag     = b_neg ? -SrcB : SrcB;

`ifdef MULDIV_FASTPATH_EN
   assign in_ovf   = in_is_div & ~MulDivOp[0] & (SrcA == MIN_NEG) & (SrcB == '1);
   assign fast_hit = (SrcA == '0) || (SrcB == '0) || in_ovf;
   always_comb begin
      fast_val = '0;
      if (in_is_div) begin
         if (SrcB == '0)
            fast_val = MulDivOp[1] ? SrcA : '1;
         else if (in_ovf)
            fast_val = MulDivOp[1] ? '0 : MIN_NEG;
      end
   end
`endif

   // One iteration step of each datapath
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH+1:0] div_shift, div_diff;
   assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? b_q : {WIDTH{1'b0}})};
   assign div_shift = {rem_q, quo_q[WIDTH-1]};
   assign div_diff  = div_shift - {2'b00, b_q};

   // Sign correction and half/quotient/remainder selection
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;
   assign prod_fix = neg_q ? -prod_q : prod_q;
   assign quo_fix  = neg_q ? -quo_q : quo_q;
   assign rem_fix  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

   always_comb begin
      fix_res = '0;
      case (op_q)
         3'b000:                 fix_res = prod_fix[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         fix_res = bzero_q ? '1 : quo_fix;
         default:                fix_res = bzero_q ? srca_q : rem_fix;
      endcase
`ifdef MULDIV_FASTPATH_EN
      if (fast_q)
         fix_res = fast_res_q;
`endif
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      srca_d      = srca_q;
      quo_d       = quo_q;
      rem_d       = rem_q;
      prod_d      = prod_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      neg_d       = neg_q;
      neg_rem_d   = neg_rem_q;
      bzero_d     = bzero_q;
      result_d    = result_q;
      zero_d      = zero_q;
      negf_d      = negf_q;
      out_valid_d = out_valid_q;
`ifdef MULDIV_FASTPATH_EN
      fast_d      = fast_q;
      fast_res_d  = fast_res_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (InValid) begin
               a_d       = a_mag;
               b_d       = b_mag;
               srca_d    = SrcA;
               op_d      = MulDivOp;
               neg_d     = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               bzero_d   = (SrcB == '0);
               prod_d    = {{WIDTH{1'b0}}, a_mag};
               quo_d     = a_mag;
               rem_d     = '0;
               cnt_d     = CNT_W'(WIDTH);
               state_d   = S_CALC;
`ifdef MULDIV_FASTPATH_EN
               fast_d     = fast_hit;
               fast_res_d = fast_val;
               if (fast_hit)
                  state_d = S_FIX;
`endif
            end
         end
         S_CALC: begin
            if (op_q[2]) begin
               rem_d = div_diff[WIDTH+1] ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
               quo_d = {quo_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
            end else begin
               prod_d = {mul_sum, prod_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
               state_d = S_FIX;
         end
         S_FIX: begin
            result_d    = fix_res;
            zero_d      = (fix_res == '0);
            negf_d      = fix_res[WIDTH-1];
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (OutReady) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         srca_q      <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         prod_q      <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
         neg_q       <= 1'b0;
         neg_rem_q   <= 1'b0;
         bzero_q     <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         negf_q      <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef MULDIV_FASTPATH_EN
         fast_q      <= 1'b0;
         fast_res_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         srca_q      <= srca_d;
         quo_q       <= quo_d;
         rem_q       <= rem_d;
         prod_q      <= prod_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         neg_q       <= neg_d;
         neg_rem_q   <= neg_rem_d;
         bzero_q     <= bzero_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         negf_q      <= negf_d;
         out_valid_q <= out_valid_d;
`ifdef MULDIV_FASTPATH_EN
         fast_q      <= fast_d;
         fast_res_q  <= fast_res_d;
`endif
      end
   end

   assign InReady  = (state_q == S_IDLE);
   assign Busy     = (state_q != S_IDLE);
   assign OutValid = out_valid_q;
   assign Result   = result_q;
   assign Zero     = zero_q;
   assign Negative = negf_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=32): results, flags, latency, backpressure, async reset.
module tb_muldiv_unit;
   localparam int W = 32;
`ifdef MULDIV_FASTPATH_EN
   localparam bit FAST_EN = 1'b1;
`else
   localparam bit FAST_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         InValid = 1'b0;
   logic         InReady;
   logic [W-1:0] SrcA = '0;
   logic [W-1:0] SrcB = '0;
   logic [2:0]   MulDivOp = '0;
   logic         OutValid;
   logic         OutReady = 1'b1;
   logic [W-1:0] Result;
   logic         Zero;
   logic         Negative;
   logic         Busy;

   int total = 0;
   int bad   = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n),
      .InValid(InValid), .InReady(InReady),
      .SrcA(SrcA), .SrcB(SrcB), .MulDivOp(MulDivOp),
      .OutValid(OutValid), .OutReady(OutReady),
      .Result(Result), .Zero(Zero), .Negative(Negative), .Busy(Busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called just after the accept edge; counts that edge as clock 1.
   task automatic wait_out(output int lat, output bit rdy_low);
      lat = 1;
      rdy_low = 1'b1;
      while (OutValid !== 1'b1 && lat < 200) begin
         if (InReady !== 1'b0) rdy_low = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res, input bit fast);
      int lat;
      bit rdy_low;
      int exp_lat;
      exp_lat = (FAST_EN && fast) ? 2 : W + 2;
      @(negedge clk);
      chk({tag, "_inready"}, InReady, 1);
      MulDivOp = op; SrcA = a; SrcB = b; InValid = 1'b1;
      @(posedge clk); #1;
      InValid = 1'b0;
      SrcA = $urandom; SrcB = $urandom; MulDivOp = 3'($urandom);
      wait_out(lat, rdy_low);
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_result"}, Result, exp_res);
      chk({tag, "_zero"}, Zero, (exp_res == '0));
      chk({tag, "_neg"}, Negative, exp_res[W-1]);
      chk({tag, "_inready_low"}, rdy_low, 1);
      $display("op %-8s a=0x%08h b=0x%08h result=0x%08h lat=%0d", tag, a, b, Result, lat);
      @(posedge clk); #1;
      chk({tag, "_handshake"}, OutValid, 0);
   endtask

   initial begin
      int lat;
      bit rdy_low;

      // Reset values
      #12;
      chk("rst_inready", InReady, 1);
      chk("rst_outvalid", OutValid, 0);
      chk("rst_result", Result, 0);
      chk("rst_zero", Zero, 1);
      chk("rst_neg", Negative, 0);
      chk("rst_busy", Busy, 0);
      @(negedge clk); reset_n = 1'b1;

      run_op("mul",     3'b000, 32'd50,        32'd20,        32'd1000,      1'b0);
      run_op("mulh",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
      run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 1'b0);
      run_op("mul_z",   3'b000, 32'h1234_5678, 32'd0,         32'd0,         1'b1);
      run_op("div",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
      run_op("rem",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
      run_op("divu",    3'b101, 32'd50,        32'd20,        32'd2,         1'b0);
      run_op("remu",    3'b111, 32'd50,        32'd20,        32'd10,        1'b0);
      run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);
      run_op("divu_0",  3'b101, 32'd123,       32'd0,         32'hFFFF_FFFF, 1'b1);
      run_op("remu_0",  3'b111, 32'd123,       32'd0,         32'd123,       1'b1);
      run_op("div_0",   3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b1);
      run_op("rem_0",   3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b1);

      // Backpressure: second request waits until one cycle after the handshake
      OutReady = 1'b0;
      @(negedge clk);
      MulDivOp = 3'b000; SrcA = 32'd7; SrcB = 32'd6; InValid = 1'b1;
      @(posedge clk); #1;
      SrcA = 32'd9; SrcB = 32'd9;
      wait_out(lat, rdy_low);
      chk("bp_latency", lat, W + 2);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_result_stable", Result, 42);
         chk("bp_outvalid_held", OutValid, 1);
         chk("bp_no_accept", InReady, 0);
      end
      $display("op bp_first a=7 b=6 result=%0d held 5 cycles", Result);
      @(negedge clk); OutReady = 1'b1;
      @(posedge clk); #1;
      chk("bp_handshake_ov", OutValid, 0);
      chk("bp_handshake_ir", InReady, 1);
      @(posedge clk); #1;
      chk("bp_second_accept", Busy, 1);
      InValid = 1'b0;
      wait_out(lat, rdy_low);
      chk("bp2_latency", lat, W + 2);
      chk("bp2_result", Result, 81);
      $display("op bp_second a=9 b=9 result=%0d lat=%0d", Result, lat);
      @(posedge clk); #1;

      // Asynchronous reset in the middle of CALC
      @(negedge clk);
      MulDivOp = 3'b000; SrcA = 32'd1000; SrcB = 32'd1000; InValid = 1'b1;
      @(posedge clk); #1;
      InValid = 1'b0;
      repeat (10) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("arst_busy", Busy, 0);
      chk("arst_inready", InReady, 1);
      chk("arst_outvalid", OutValid, 0);
      chk("arst_result", Result, 0);
      chk("arst_zero", Zero, 1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      lat = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(posedge clk); #1;
         if (OutValid !== 1'b0) lat++;
      end
      chk("arst_no_stale", lat, 0);
      $display("op arst aborted mid-calc, no result delivered");
      run_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the single-cycle ALU in the execute stage and generalises it to a parametrised datapath width.
- Uses a valid/ready handshake on both sides so the core can stall while the operation computes.
- Produces the ALU-style Zero/Negative flags on its result.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values 8..64, even.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- InValid  input  1  request valid.
- InReady  output  1  unit can accept a request (high only in IDLE).
- SrcA  input  WIDTH  operand A (multiplicand / dividend).
- SrcB  input  WIDTH  operand B (multiplier / divisor).
- MulDivOp  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OutValid  output  1  Result valid.
- OutReady  input  1  consumer accepts Result.
- Result  output  WIDTH  operation result.
- Zero  output  1  Result == 0; qualified by OutValid.
- Negative  output  1  Result[WIDTH-1]; qualified by OutValid.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_n low): state=IDLE, InReady=1, OutValid=0, Result=0, Zero=1, Negative=0, Busy=0, all internal registers cleared. Reset asserted mid-operation aborts it immediately; no result is delivered.
- State machine: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - InReady=1.
  - On InValid&&InReady, latch SrcA, SrcB and MulDivOp.
  - Convert signed operands to magnitudes and record result sign(s).
  - Set counter=WIDTH and go to CALC.
- CALC:
  - One bit per cycle.
  - Multiply: shift-add over a 2*WIDTH product register.
  - Divide: restoring division; remainder register WIDTH+1 bits.
  - Counter decrements each cycle; when it reaches 1, go to FIX.
  - Exactly WIDTH cycles in CALC.
- FIX:
  - Apply sign correction.
  - Select the low half (MUL), the high half (MULH*), the quotient (DIV*) or the remainder (REM*).
  - Register Result, Zero and Negative; set OutValid=1; go to DONE.
- DONE:
  - Hold Result/OutValid stable until OutReady.
  - On OutReady: OutValid=0, go to IDLE.
- Latency: request accept edge to OutValid high = WIDTH+2 clocks. Throughput: one operation per WIDTH+3 clocks with OutReady tied high.
- Back-to-back: InReady stays 0 in DONE even when OutReady=1. A new request is accepted no earlier than the cycle after the handshake.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: SrcA signed, SrcB unsigned.
  - MULHU and MUL: unsigned magnitudes; MUL low half is sign-agnostic.
  - DIV/REM: signed. Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- Divide by zero (SrcB==0): DIV/DIVU return all ones; REM/REMU return SrcA.
- Signed overflow (SrcA = most-negative, SrcB = -1): DIV returns most-negative; REM returns 0.
- Special-case results (divide by zero and signed overflow) are still delivered with full WIDTH+2 latency unless the optional feature is enabled.
- Inputs are sampled only on the accept edge; later changes to SrcA/SrcB/MulDivOp are ignored.

Optional Feature:
- Macro: MULDIV_FASTPATH_EN.
- Defined:
  - In IDLE, detect divide by zero, signed overflow, SrcA==0 or SrcB==0 (all ops).
  - On detection, skip CALC: go directly to FIX, then DONE, giving a latency of 2 clocks.
  - Results are identical to the slow path.
- Undefined: all operations take WIDTH+2 clocks and no detection logic is synthesised.

Test Plan:
- WIDTH=32, MUL with SrcA=50, SrcB=20, OutReady=1 -> OutValid exactly 34 clocks after accept, Result=1000, Zero=0, Negative=0; InReady=0 throughout.
- MULH with 0x80000000 x 0x80000000 -> Result=0x40000000. MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> Result=-3 (Negative=1). REM -7/2 -> -1. DIVU 50/20 -> 2. REMU 50/20 -> 10.
- DIV 0x80000000 / -1 -> 0x80000000; REM of the same operands -> 0 (Zero=1). DIVU 123/0 -> 0xFFFFFFFF; REMU 123/0 -> 123. With MULDIV_FASTPATH_EN, each of these completes in 2 clocks.
- Backpressure: OutReady held 0 for 5 cycles after OutValid -> Result stable and no new accept while InValid=1; the second request is accepted one cycle after the handshake.
- Drop reset_n in the middle of CALC -> outputs return to reset values asynchronously. After release, a fresh MUL 3x4 returns 12 with no stale result.
